// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : 8N1 UART receiver feeding a first-word-fall-through byte FIFO
//            that drains through a valid/ready interface.
// Ports    : clk_i          - system clock, rising edge
//            rst_n_i        - asynchronous active-low reset
//            uart_rx_data_i - serial input, idles high, asynchronous
//            m_data_o       - byte at the FIFO head
//            m_valid_o      - FIFO non-empty
//            m_ready_i      - consumer pops the head on valid && ready
//            rx_busy_o      - receiver is inside a frame
//            frame_err_o    - one-cycle pulse, stop bit sampled low
//            overrun_o      - sticky, good byte dropped because FIFO full
//            err_clr_i      - clears overrun_o (a new overrun wins)
//            fifo_count_o   - current FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic                          uart_rx_data_i,
   output logic [7:0]                    m_data_o,
   output logic                          m_valid_o,
   input  logic                          m_ready_i,
   output logic                          rx_busy_o,
   output logic                          frame_err_o,
   output logic                          overrun_o,
   input  logic                          err_clr_i,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);

   localparam logic [BW-1:0] HALF_CNT = BW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] LAST_CNT = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t          state;
   logic [BW-1:0]   baud_cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shift;
   logic            rx_meta;
   logic            rx_s;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;

   logic            stop_sample;
   logic            push_req;
   logic            pop;
   logic            full;
   logic            push;
   logic            overrun_set;

   // Two-flop synchroniser, preset to the idle (high) line level.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= uart_rx_data_i;
         rx_s    <= rx_meta;
      end
   end

   // A pop in the same cycle frees the slot the incoming byte needs.
   assign stop_sample = (state == STOP) && (baud_cnt == LAST_CNT);
   assign push_req    = stop_sample && rx_s;
   assign pop         = m_valid_o && m_ready_i;
   assign full        = (count == DEPTH_C);
   assign push        = push_req && (!full || pop);
   assign overrun_set = push_req && full && !pop;

   // Receiver FSM with its registered status outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state       <= IDLE;
         baud_cnt    <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
      end else begin
         frame_err_o <= stop_sample && !rx_s;

         if (overrun_set) begin
            overrun_o <= 1'b1;
         end else if (err_clr_i) begin
            overrun_o <= 1'b0;
         end

         case (state)
            IDLE: begin
               baud_cnt <= '0;
               bit_idx  <= '0;
               if (!rx_s) begin
                  state <= START;
               end
            end
            START: begin
               if (baud_cnt == HALF_CNT) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  // A line that is high again at mid start bit was a glitch.
                  state    <= rx_s ? IDLE : DATA;
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            DATA: begin
               if (baud_cnt == LAST_CNT) begin
                  baud_cnt        <= '0;
                  shift[bit_idx]  <= rx_s;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            STOP: begin
               // Leaving at mid stop bit lets a following start edge be
               // caught with no idle gap between frames.
               if (baud_cnt == LAST_CNT) begin
                  baud_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            default: begin
               state    <= IDLE;
               baud_cnt <= '0;
            end
         endcase
      end
   end

   assign rx_busy_o = (state != IDLE);

   // FIFO storage, pointers and occupancy.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= shift;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign m_valid_o    = (count != '0);
   assign m_data_o     = mem[rd_ptr];
   assign fifo_count_o = count;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Self-checking bench for uart_rx_fifo. A UART driver sends 8N1
//            frames; a reference FIFO queue predicts the byte stream and a
//            negedge monitor compares every popped byte against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

   localparam int CPB   = 16;
   localparam int DEPTH = 8;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       uart      = 1'b1;
   logic       m_ready   = 1'b0;
   logic       err_clr   = 1'b0;
   logic [7:0] m_data;
   logic       m_valid;
   logic       rx_busy;
   logic       frame_err;
   logic       overrun;
   logic [3:0] fifo_count;

   int         checks      = 0;
   int         errors      = 0;
   int         exp_ferr    = 0;
   int         ferr_cycles = 0;
   logic       exp_overrun = 1'b0;
   bit         rand_ready  = 1'b0;
   logic [7:0] exp_q [$];
   logic [7:0] mon_exp;

   uart_rx_fifo #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .uart_rx_data_i (uart),
      .m_data_o       (m_data),
      .m_valid_o      (m_valid),
      .m_ready_i      (m_ready),
      .rx_busy_o      (rx_busy),
      .frame_err_o    (frame_err),
      .overrun_o      (overrun),
      .err_clr_i      (err_clr),
      .fifo_count_o   (fifo_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d", name, act, req);
      end
   endtask

   // Hold the line at a level for n bit-clocks; ends just after a rising edge.
   task automatic drive(input logic v, input int n);
      uart = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Sends one frame. The reference decision is taken just after the monitor
   // has handled the handshake of the mid-stop-bit edge, so the queue size is
   // the FIFO occupancy seen by the incoming byte.
   task automatic send_frame(input logic [7:0] b, input logic stop);
      drive(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive(b[i], CPB);
      uart = stop;
      repeat (CPB / 2 + 2) @(posedge clk);
      @(negedge clk);
      #1;
      if (!stop) exp_ferr++;
      else if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else exp_overrun = 1'b1;
      repeat (CPB / 2 - 2) @(posedge clk);
      #1;
      uart = 1'b1;
   endtask

   task automatic drain(input string name);
      m_ready = 1'b1;
      for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      chk(name, exp_q.size(), 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, m_valid, 0);
      chk({tag, "_data"}, m_data, 0);
      chk({tag, "_count"}, fifo_count, 0);
      chk({tag, "_busy"}, rx_busy, 0);
      chk({tag, "_ferr"}, frame_err, 0);
      chk({tag, "_overrun"}, overrun, 0);
   endtask

   // Scoreboard monitor: every accepted beat must match the queue head.
   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_err) ferr_cycles++;
         if (m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL pop_unexpected: actual data 0x%02h required no byte", m_data);
            end else begin
               mon_exp = exp_q.pop_front();
               if (m_data !== mon_exp) begin
                  errors++;
                  $display("FAIL pop_data: actual 0x%02h required 0x%02h", m_data, mon_exp);
               end
            end
         end
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         m_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: actual no finish required finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] b;
      logic       stop;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      drive(1'b1, CPB);

      // Single frame, consumer always ready
      m_ready = 1'b1;
      send_frame(8'hA5, 1'b1);
      drive(1'b1, CPB);
      chk("a5_count", fifo_count, 0);
      drain("a5_drain");
      chk("a5_ferr", ferr_cycles, 0);

      // Fill back-to-back, then overrun
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) send_frame(8'(i), 1'b1);
      drive(1'b1, 4);
      chk("fill_count", fifo_count, 8);
      send_frame(8'h08, 1'b1);
      drive(1'b1, 4);
      chk("ovr_flag", overrun, exp_overrun);
      chk("ovr_count", fifo_count, 8);
      drain("fill_drain");
      chk("fill_drained_count", fifo_count, 0);
      chk("ovr_sticky", overrun, 1);
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      exp_overrun = 1'b0;
      chk("ovr_cleared", overrun, exp_overrun);

      // 4-cycle low glitch is a false start
      drive(1'b0, 4);
      drive(1'b1, 1);
      chk("glitch_busy_hi", rx_busy, 1);
      drive(1'b1, 2 * CPB);
      chk("glitch_busy_lo", rx_busy, 0);
      chk("glitch_count", fifo_count, 0);
      chk("glitch_ferr", ferr_cycles, exp_ferr);
      chk("glitch_overrun", overrun, 0);

      // Bad stop bit, then a good frame
      send_frame(8'h3C, 1'b0);
      drive(1'b1, 2 * CPB);
      chk("ferr_pulse_cycles", ferr_cycles, exp_ferr);
      chk("ferr_count", fifo_count, 0);
      send_frame(8'h5A, 1'b1);
      drive(1'b1, CPB);
      drain("5a_drain");

      // Reset in the middle of data bit 4
      m_ready = 1'b0;
      send_frame(8'h42, 1'b1);
      drive(1'b1, 4);
      chk("pre_rst_count", fifo_count, 1);
      b = 8'h81;
      drive(1'b0, CPB);
      for (int i = 0; i < 4; i++) drive(b[i], CPB);
      uart = b[4];
      repeat (CPB / 2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk_reset_outputs("async_rst");
      uart = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1'b1, CPB);
      m_ready = 1'b1;
      send_frame(8'h81, 1'b1);
      drive(1'b1, CPB);
      drain("post_rst_drain");
      chk("post_rst_count", fifo_count, 0);

      // Full FIFO, pop on the exact write edge of 0xEE
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) send_frame(8'($urandom), 1'b1);
      drive(1'b1, 4);
      chk("full_count", fifo_count, 8);
      fork
         send_frame(8'hEE, 1'b1);
         begin
            repeat (9 * CPB + CPB / 2 + 2) @(posedge clk);
            #1;
            m_ready = 1'b1;
            @(posedge clk);
            #1;
            m_ready = 1'b0;
         end
      join
      chk("ee_overrun", overrun, exp_overrun);
      chk("ee_count", fifo_count, 8);
      drain("ee_drain");

      // Randomised frames, errors and consumer back-pressure
      rand_ready = 1'b1;
      for (int n = 0; n < 24; n++) begin
         b    = 8'($urandom);
         stop = ($urandom_range(0, 4) != 0);
         send_frame(b, stop);
         if (!stop) drive(1'b1, 2 * CPB);
         else if ($urandom_range(0, 1) == 1) drive(1'b1, $urandom_range(1, CPB));
      end
      rand_ready = 1'b0;
      @(posedge clk);
      #2;
      drain("rand_drain");
      chk("rand_ferr", ferr_cycles, exp_ferr);
      chk("rand_overrun", overrun, exp_overrun);
      chk("rand_count", fifo_count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial UART receiver with a byte FIFO. It sits directly downstream of top_uart_tx_app and consumes its uart_tx_data_o line.
- Deserialises 8N1 frames, checks the stop bit, and buffers received bytes in a first-word-fall-through FIFO.
- The FIFO drains through a valid/ready byte interface to the application or bench checker.

Parameters:
- CLKS_PER_BIT, 16, clk_i cycles per UART bit. Must be at least 4. Equals DEFAULT_CLOCK_IN / DEFAULT_SEND_RATE of the transmitter.
- FIFO_DEPTH, 8, FIFO entries. Power of two, at least 2.

Ports:
- clk_i  in  1  system clock; all logic on the rising edge
- rst_n_i  in  1  asynchronous active-low reset
- uart_rx_data_i  in  1  serial input; idles high; asynchronous to clk_i
- m_data_o  out  8  byte at the FIFO head
- m_valid_o  out  1  FIFO non-empty; m_data_o is valid
- m_ready_i  in  1  consumer pops the head when m_valid_o && m_ready_i
- rx_busy_o  out  1  high while a frame is being received (any state except IDLE)
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low
- overrun_o  out  1  sticky flag: a good byte arrived while the FIFO was full
- err_clr_i  in  1  clears overrun_o
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset: clk_i and rst_n_i as already decided (one clock; reset asynchronous, active-low). While rst_n_i=0:
  - FSM in IDLE; bit counter and baud counter at 0.
  - Synchroniser flops preset to 1.
  - FIFO emptied: pointers 0, fifo_count_o=0, m_valid_o=0, m_data_o=0x00.
  - rx_busy_o=0, frame_err_o=0, overrun_o=0.
  - Reset mid-frame discards the partial byte. After release, the receiver waits for a fresh high-to-low edge.
- Input synchronisation: 2-flop synchroniser; rx_s is the second flop output. All decisions below use rx_s.
- Baud counter: counts 0..CLKS_PER_BIT-1; cleared on every state entry.
- IDLE:
  - rx_s=0 -> go to START.
- START:
  - At count CLKS_PER_BIT/2-1 (integer division; mid start bit), sample rx_s.
  - rx_s=0 -> go to DATA, bit index 0.
  - rx_s=1 -> false start; go to IDLE, no flags raised.
- DATA:
  - At count CLKS_PER_BIT-1, sample rx_s into shift bit [index], LSB first.
  - After bit 7 -> go to STOP.
- STOP:
  - At count CLKS_PER_BIT-1 (mid stop bit), sample rx_s and go to IDLE in the same edge. This allows back-to-back frames with no idle gap.
  - rx_s=1 and FIFO has room (or a pop occurs the same cycle) -> write byte; m_valid_o is high on the following cycle.
  - rx_s=1 and FIFO full with no pop -> drop byte; set overrun_o.
  - rx_s=0 -> frame_err_o pulses for exactly that one following cycle; byte discarded.
- Latency: from the mid-stop-bit sample edge, m_valid_o (FIFO previously empty) and m_data_o are updated on the next rising edge.
- FIFO behaviour:
  - Read pointer and write pointer, each $clog2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH.
  - Count register for full/empty.
  - m_data_o always shows the head entry (first-word fall-through).
- Simultaneous push and pop:
  - Empty: pop is not possible (m_valid_o=0); push proceeds.
  - Full: pop frees the slot and push is accepted; count unchanged.
  - Otherwise: count unchanged, both pointers advance.
- Pop when empty: ignored; m_ready_i is don't-care while m_valid_o=0.
- overrun_o clear:
  - err_clr_i clears overrun_o.
  - If err_clr_i and a new overrun occur in the same cycle, set wins.

Test Plan:
- CLKS_PER_BIT=16, m_ready_i=1. Drive 8N1 frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) -> one beat m_data_o=0xA5 with m_valid_o=1, frame_err_o=0, fifo_count_o returns to 0.
- m_ready_i=0. Send 0x00..0x07 back-to-back with no idle gap -> fifo_count_o=8. Ninth byte 0x08 -> overrun_o=1, count stays 8. Then raise m_ready_i -> pops 0x00..0x07 in order. Pulse err_clr_i -> overrun_o=0.
- Low glitch on uart_rx_data_i of 4 clk_i cycles -> false start; rx_busy_o returns to 0, no byte, no error flags.
- Frame 0x3C with stop bit driven 0 -> frame_err_o high for exactly one cycle; fifo_count_o unchanged. Next valid frame 0x5A is received correctly.
- Assert rst_n_i=0 in the middle of data bit 4 -> all outputs at reset values immediately (asynchronous). After release, frame 0x81 -> m_data_o=0x81, no stale data.
- FIFO full (8 entries). Hold m_ready_i=1 on the exact edge a new byte 0xEE is written -> no overrun; count stays 8; 0xEE is the last entry read.
